dpmem_arb: RTL and testbench

//  Upstream controller for one dpmem instance. Two requesters (A: fetch, B: load/store) issue req/we/addr/wdata.

---
 rtl/dpmem_arb.sv | 179 +++++++++++++++++
 tb/tb_dpmem_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpmem_arb.sv
// dpmem_arb: two-requester front end for a dual-port memory (dpmem).
// Requester A (fetch) drives memory port A and requester B (load/store) drives port B.
// A same-address read/write collision is resolved by stalling the losing requester for one cycle.
// Reads return registered data two cycles after the grant.
// Optional feature: define RANGE_CHK_EN to turn on address range checking against MEM_SIZE.
module dpmem_arb #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MEM_SIZE   = 1024
) (
   input  logic                  clk_i,
   input  logic                  reset_b_i,
   input  logic                  a_req_i,
   input  logic                  a_we_i,
   input  logic [ADDR_WIDTH-1:0] a_addr_i,
   input  logic [31:0]           a_wdata_i,
   input  logic                  b_req_i,
   input  logic                  b_we_i,
   input  logic [ADDR_WIDTH-1:0] b_addr_i,
   input  logic [31:0]           b_wdata_i,
   output logic                  a_gnt_o,
   output logic                  b_gnt_o,
   output logic                  a_rvalid_o,
   output logic                  b_rvalid_o,
   output logic [31:0]           a_rdata_o,
   output logic [31:0]           b_rdata_o,
   output logic                  a_err_o,
   output logic                  b_err_o,
   output logic [15:0]           stall_cnt_o,
   output logic [ADDR_WIDTH-1:0] addra_o,
   output logic [ADDR_WIDTH-1:0] addrb_o,
   output logic                  wea_o,
   output logic                  web_o,
   output logic                  oea_o,
   output logic                  oeb_o,
   output logic [31:0]           da_o,
   output logic [31:0]           db_o,
   input  logic [31:0]           qa_i,
   input  logic [31:0]           qb_i
);

   typedef enum logic [1:0] {StIdle, StRdWait, StRdCap} state_e;

   // Index 0 is channel A, index 1 is channel B.
   logic [1:0]                 req, we, gnt, lose, can_issue, in_rng;
   logic [1:0]                 mem_we, mem_oe, rvalid, err;
   logic [1:0][ADDR_WIDTH-1:0] addr, mem_addr;
   logic [1:0][31:0]           wdata, q, mem_d;
   logic                       conflict;

   state_e                     state_q [2];
   state_e                     state_d [2];
   logic [1:0][ADDR_WIDTH-1:0] maddr_q, maddr_d;
   logic [1:0][31:0]           rdata_q, rdata_d;
   logic [1:0]                 oor_q, oor_d;
   logic [15:0]                stall_q, stall_d;

   assign req   = {b_req_i, a_req_i};
   assign we    = {b_we_i, a_we_i};
   assign addr  = {b_addr_i, a_addr_i};
   assign wdata = {b_wdata_i, a_wdata_i};
   assign q     = {qb_i, qa_i};

`ifdef RANGE_CHK_EN
   localparam logic [ADDR_WIDTH-1:0] MaxAddr = ADDR_WIDTH'(MEM_SIZE - 1);

   // Flag requests that fall outside the attached memory.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         in_rng[i] = (addr[i] <= MaxAddr);
      end
   end
`else
   assign in_rng = 2'b11;
`endif

   // Arbitration: a same-address collision involving a write stalls one side.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         can_issue[i] = (state_q[i] == StIdle) || (state_q[i] == StRdCap);
      end
      conflict = (&can_issue) & (&req) & (addr[0] == addr[1]) & (|we) & (&in_rng);
      // A writing: B loses (both-write or B read). A reading: B must be the writer, A loses.
      lose[0]  = conflict & ~we[0];
      lose[1]  = conflict & we[0];
      gnt      = can_issue & req & ~lose;
   end

   // Per-channel read FSM and memory port drive.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_d[i]  = state_q[i];
         maddr_d[i]  = maddr_q[i];
         rdata_d[i]  = rdata_q[i];
         oor_d[i]    = oor_q[i];
         mem_we[i]   = 1'b0;
         mem_oe[i]   = 1'b0;
         mem_d[i]    = '0;
         rvalid[i]   = 1'b0;
         err[i]      = 1'b0;
         mem_addr[i] = gnt[i] ? addr[i] : maddr_q[i];
         unique case (state_q[i])
            StIdle, StRdCap: begin
               rvalid[i]  = (state_q[i] == StRdCap);
`ifdef RANGE_CHK_EN
               err[i]     = rvalid[i] & oor_q[i];
`endif
               state_d[i] = StIdle;
               if (gnt[i]) begin
                  maddr_d[i] = addr[i];
                  if (we[i]) begin
                     mem_we[i] = in_rng[i];
                     mem_d[i]  = wdata[i];
`ifdef RANGE_CHK_EN
                     err[i]    = err[i] | ~in_rng[i];
`endif
                  end else begin
                     state_d[i] = StRdWait;
                     oor_d[i]   = ~in_rng[i];
                  end
               end
            end
            StRdWait: begin
               mem_oe[i]  = ~oor_q[i];
               rdata_d[i] = oor_q[i] ? '0 : q[i];
               state_d[i] = StRdCap;
            end
            default: state_d[i] = StIdle;
         endcase
      end
   end

   // Saturating count of cycles in which a pending request lost arbitration.
   always_comb begin
      stall_d = stall_q;
      if ((|lose) && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   // State registers; reset drops any read in flight.
   always_ff @(posedge clk_i or negedge reset_b_i) begin
      if (!reset_b_i) begin
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= StIdle;
         end
         maddr_q <= '0;
         rdata_q <= '0;
         oor_q   <= '0;
         stall_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= state_d[i];
         end
         maddr_q <= maddr_d;
         rdata_q <= rdata_d;
         oor_q   <= oor_d;
         stall_q <= stall_d;
      end
   end

   assign a_gnt_o     = gnt[0];
   assign b_gnt_o     = gnt[1];
   assign a_rvalid_o  = rvalid[0];
   assign b_rvalid_o  = rvalid[1];
   assign a_rdata_o   = rdata_q[0];
   assign b_rdata_o   = rdata_q[1];
   assign a_err_o     = err[0];
   assign b_err_o     = err[1];
   assign stall_cnt_o = stall_q;
   assign addra_o     = mem_addr[0];
   assign addrb_o     = mem_addr[1];
   assign wea_o       = mem_we[0];
   assign web_o       = mem_we[1];
   assign oea_o       = mem_oe[0];
   assign oeb_o       = mem_oe[1];
   assign da_o        = mem_d[0];
   assign db_o        = mem_d[1];

endmodule

// File: tb/tb_dpmem_arb.sv
// Bench for dpmem_arb: vector table of per-cycle requests with expected grants, strobes and
// stall count, a read-data scoreboard, plus hand sequences for port timing and reset mid-read.
module tb_dpmem_arb;

   logic        clk = 1'b0;
   logic        reset_b;
   logic        a_req, a_we, b_req, b_we;
   logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
   logic        a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic [15:0] stall_cnt;
   logic [31:0] addra, addrb, da, db, qa, qb;
   logic        wea, web, oea, oeb;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dpmem_arb #(
      .ADDR_WIDTH(32),
      .MEM_SIZE  (1024)
   ) dut (
      .clk_i      (clk),
      .reset_b_i  (reset_b),
      .a_req_i    (a_req),
      .a_we_i     (a_we),
      .a_addr_i   (a_addr),
      .a_wdata_i  (a_wdata),
      .b_req_i    (b_req),
      .b_we_i     (b_we),
      .b_addr_i   (b_addr),
      .b_wdata_i  (b_wdata),
      .a_gnt_o    (a_gnt),
      .b_gnt_o    (b_gnt),
      .a_rvalid_o (a_rvalid),
      .b_rvalid_o (b_rvalid),
      .a_rdata_o  (a_rdata),
      .b_rdata_o  (b_rdata),
      .a_err_o    (a_err),
      .b_err_o    (b_err),
      .stall_cnt_o(stall_cnt),
      .addra_o    (addra),
      .addrb_o    (addrb),
      .wea_o      (wea),
      .web_o      (web),
      .oea_o      (oea),
      .oeb_o      (oeb),
      .da_o       (da),
      .db_o       (db),
      .qa_i       (qa),
      .qb_i       (qb)
   );

   // Memory model: synchronous write, registered read of the address presented this cycle.
   logic [31:0] mem [1024];
   always @(posedge clk) begin
      if (wea) mem[addra[9:0]] <= da;
      if (web) mem[addrb[9:0]] <= db;
      qa <= mem[addra[9:0]];
      qb <= mem[addrb[9:0]];
   end

   typedef struct {
      logic        aq, aw;
      logic [31:0] aa, ad;
      logic        bq, bw;
      logic [31:0] ba, bd;
      logic        eag, ebg, ear, ebr;
      logic [15:0] est;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] ref_mem [1024];
   logic [31:0] sb_a[$];
   logic [31:0] sb_b[$];

   function automatic vec_t mk(logic aq, logic aw, logic [31:0] aa, logic [31:0] ad,
                               logic bq, logic bw, logic [31:0] ba, logic [31:0] bd,
                               logic eag, logic ebg, logic ear, logic ebr, logic [15:0] est);
      vec_t v;
      v.aq = aq; v.aw = aw; v.aa = aa; v.ad = ad;
      v.bq = bq; v.bw = bw; v.ba = ba; v.bd = bd;
      v.eag = eag; v.ebg = ebg; v.ear = ear; v.ebr = ebr; v.est = est;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic aq, logic aw, logic [31:0] aa, logic [31:0] ad,
                        logic bq, logic bw, logic [31:0] ba, logic [31:0] bd);
      a_req = aq; a_we = aw; a_addr = aa; a_wdata = ad;
      b_req = bq; b_we = bw; b_addr = ba; b_wdata = bd;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
   endtask

   task automatic chk_all_zero(string name);
      chk({name, "_strobes"}, {22'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err,
                               wea, web, oea, oeb}, 32'd0);
      chk({name, "_a_rdata"}, a_rdata, 32'd0);
      chk({name, "_b_rdata"}, b_rdata, 32'd0);
      chk({name, "_stall"}, {16'd0, stall_cnt}, 32'd0);
      chk({name, "_addr"}, addra | addrb, 32'd0);
      chk({name, "_d"}, da | db, 32'd0);
   endtask

   initial begin
      reset_b = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

      //        aq aw aa        ad            bq bw ba        bd            ag bg ar br st
      vecs.push_back(mk(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0,                1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h10, 0,            0, 0, 0, 0,                1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,      0,            0, 0, 0, 0,                0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h10, 0,            0, 0, 0, 0,                1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0,      0,            0, 0, 0, 0,                0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,      0,            0, 0, 0, 0,                0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 1, 32'h20, 32'hCAFEF00D, 1, 0, 32'h20, 0,           1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0,      0,            1, 0, 32'h20, 0,           0, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,      0,            0, 0, 0, 0,                0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,      0,            0, 0, 0, 0,                0, 0, 0, 1, 1));
      vecs.push_back(mk(1, 1, 32'h30, 32'd1,        1, 1, 32'h30, 32'd2,       1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,      0,            1, 1, 32'h30, 32'd2,       0, 1, 0, 0, 2));
      vecs.push_back(mk(1, 0, 32'h30, 0,            0, 0, 0, 0,                1, 0, 0, 0, 2));
      vecs.push_back(mk(0, 0, 0,      0,            0, 0, 0, 0,                0, 0, 0, 0, 2));
      vecs.push_back(mk(0, 0, 0,      0,            0, 0, 0, 0,                0, 0, 1, 0, 2));
      vecs.push_back(mk(1, 1, 32'h40, 32'h11111111, 1, 1, 32'h41, 32'h22222222, 1, 1, 0, 0, 2));
      vecs.push_back(mk(1, 0, 32'h40, 0,            1, 0, 32'h41, 0,           1, 1, 0, 0, 2));
      vecs.push_back(mk(0, 0, 0,      0,            0, 0, 0, 0,                0, 0, 0, 0, 2));
      vecs.push_back(mk(0, 0, 0,      0,            0, 0, 0, 0,                0, 0, 1, 1, 2));
      vecs.push_back(mk(1, 0, 32'h50, 0,            1, 1, 32'h50, 32'h55555555, 0, 1, 0, 0, 2));
      vecs.push_back(mk(1, 0, 32'h50, 0,            0, 0, 0, 0,                1, 0, 0, 0, 3));
      vecs.push_back(mk(0, 0, 0,      0,            0, 0, 0, 0,                0, 0, 0, 0, 3));
      vecs.push_back(mk(0, 0, 0,      0,            0, 0, 0, 0,                0, 0, 1, 0, 3));
      vecs.push_back(mk(1, 0, 32'h10, 0,            1, 0, 32'h10, 0,           1, 1, 0, 0, 3));
      vecs.push_back(mk(0, 0, 0,      0,            0, 0, 0, 0,                0, 0, 0, 0, 3));
      vecs.push_back(mk(0, 0, 0,      0,            0, 0, 0, 0,                0, 0, 1, 1, 3));

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      reset_b = 1'b1;

      // Vector table with read-data scoreboard
      foreach (vecs[k]) begin
         vec_t v;
         v = vecs[k];
         @(negedge clk);
         drive(v.aq, v.aw, v.aa, v.ad, v.bq, v.bw, v.ba, v.bd);
         #1;
         chk($sformatf("v%0d_a_gnt", k), {31'd0, a_gnt}, {31'd0, v.eag});
         chk($sformatf("v%0d_b_gnt", k), {31'd0, b_gnt}, {31'd0, v.ebg});
         chk($sformatf("v%0d_a_rvalid", k), {31'd0, a_rvalid}, {31'd0, v.ear});
         chk($sformatf("v%0d_b_rvalid", k), {31'd0, b_rvalid}, {31'd0, v.ebr});
         chk($sformatf("v%0d_stall", k), {16'd0, stall_cnt}, {16'd0, v.est});
         if (a_rvalid) begin
            if (sb_a.size() == 0) chk($sformatf("v%0d_a_unexpected_rvalid", k), 32'd1, 32'd0);
            else chk($sformatf("v%0d_a_rdata", k), a_rdata, sb_a.pop_front());
         end
         if (b_rvalid) begin
            if (sb_b.size() == 0) chk($sformatf("v%0d_b_unexpected_rvalid", k), 32'd1, 32'd0);
            else chk($sformatf("v%0d_b_rdata", k), b_rdata, sb_b.pop_front());
         end
         if (v.eag && v.aq) begin
            if (v.aw) ref_mem[v.aa[9:0]] = v.ad;
            else sb_a.push_back(ref_mem[v.aa[9:0]]);
         end
         if (v.ebg && v.bq) begin
            if (v.bw) ref_mem[v.ba[9:0]] = v.bd;
            else sb_b.push_back(ref_mem[v.ba[9:0]]);
         end
      end
      chk("sb_drained", sb_a.size() + sb_b.size(), 32'd0);

      // Memory port timing for a write then a read
      @(negedge clk);
      drive(1, 1, 32'h60, 32'h12345678, 0, 0, 0, 0);
      #1;
      chk("port_wr_wea_oea", {30'd0, wea, oea}, 32'd2);
      chk("port_wr_da", da, 32'h12345678);
      chk("port_wr_addra", addra, 32'h60);
      idle_cycle();
      chk("port_idle_wea_oea", {30'd0, wea, oea}, 32'd0);
      chk("port_idle_addr_hold", addra, 32'h60);
      @(negedge clk);
      drive(1, 0, 32'h60, 0, 0, 0, 0, 0);
      #1;
      chk("port_rd_gnt_we", {30'd0, a_gnt, wea}, 32'd2);
      idle_cycle();
      chk("port_rdwait_oea_gnt", {30'd0, oea, a_gnt}, 32'd2);
      chk("port_rdwait_addra", addra, 32'h60);
      idle_cycle();
      chk("port_rdcap_rvalid", {31'd0, a_rvalid}, 32'd1);
      chk("port_rdcap_rdata", a_rdata, 32'h12345678);
      idle_cycle();
      chk("port_after_rvalid", {31'd0, a_rvalid}, 32'd0);
      chk("port_rdata_held", a_rdata, 32'h12345678);

      // Reset asserted while a read waits for data
      @(negedge clk);
      drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
      #1;
      chk("rstrd_gnt", {31'd0, a_gnt}, 32'd1);
      idle_cycle();
      chk("rstrd_in_wait", {31'd0, oea}, 32'd1);
      reset_b = 1'b0;
      #1;
      chk_all_zero("rstrd_asserted");
      repeat (2) @(negedge clk);
      reset_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         idle_cycle();
         chk($sformatf("rstrd_no_rvalid_%0d", i), {30'd0, a_rvalid, b_rvalid}, 32'd0);
      end
      chk_all_zero("rstrd_released");

`ifdef RANGE_CHK_EN
      // Out-of-range requests
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 0, 32'h10, 0);
      #1;
      repeat (2) idle_cycle();
      chk("rng_pre_rdata", b_rdata, 32'hDEADBEEF);
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 1, 32'd1024, 32'hA5A5A5A5);
      #1;
      chk("rng_wr_gnt_err_web", {29'd0, b_gnt, b_err, web}, 32'd6);
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 0, 32'd1024, 0);
      #1;
      chk("rng_rd_gnt_err", {30'd0, b_gnt, b_err}, 32'd2);
      idle_cycle();
      chk("rng_rdwait_oeb", {31'd0, oeb}, 32'd0);
      idle_cycle();
      chk("rng_rd_rvalid_err", {30'd0, b_rvalid, b_err}, 32'd3);
      chk("rng_rd_rdata", b_rdata, 32'd0);
      idle_cycle();
      chk("rng_err_clear", {31'd0, b_err}, 32'd0);
`else
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 1, 32'd1024, 32'hA5A5A5A5);
      #1;
      chk("norng_wr_gnt_err_web", {29'd0, b_gnt, b_err, web}, 32'd5);
      idle_cycle();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
